up_seq_core: RTL and testbench
==============================

// Module: up_seq_core
// PURPOSE
//  Parametrised accumulator CPU core with an explicit fetch/execute FSM. Successor to the 4-bit uP datapath.
//  Adds variable-latency program-memory handshake, 2-word addressed instructions, conditional jumps,
//  CALL/RET hardware stack and HALT/fault states.
//  Sits between program ROM, data RAM and the board I/O (pushbuttons / LEDs).
// PARAMETERS
//  DW           4   data/accumulator width; operand field width (DW>=1)
//  AW           12  program and data address width (AW <= 2*DW+4)
//  STACK_DEPTH  4   CALL return-address entries (>=1)
// PORTS
//  clock         in   1     rising-edge clock
//  reset         in   1     synchronous, active-low reset
//  enable        in   1     1 = run; 0 = stall at next fetch
//  pm_req        out  1     program-memory request
//  pm_addr       out  AW    program word address (= pc)
//  pm_ack        in   1     rdata valid this cycle; completes request
//  pm_rdata      in   DW+4  instruction word {opcode[3:0], oprnd[DW-1:0]}
//  dm_addr       out  AW    data RAM address
//  dm_we         out  1     write strobe, 1 cycle
//  dm_re         out  1     read strobe; dm_rdata valid next cycle
//  dm_wdata      out  DW    = accu
//  dm_rdata      in   DW    read data
//  in_port       in   DW    pushbuttons
//  out_port      out  DW    output register
//  out_valid     out  1     1-cycle pulse on OUT
//  pc            out  AW    program counter
//  instr, oprnd  out  4,DW  latched first instruction word
//  accu          out  DW    accumulator
//  c_flag,z_flag out  1     carry/borrow, zero
//  phase         out  1     1 in EXEC/MEMWAIT, 0 in fetch states
//  halted,fault  out  1     HALT reached; stack over/underflow
// BEHAVIOUR
//  Reset (reset==0 at edge): all regs/outputs 0, state=FETCH; all strobes 0 that cycle; pending ack ignored.
//  FSM states: FETCH, FETCH2, EXEC, MEMWAIT, HALT.
//  - FETCH: pm_req=enable, pm_addr=pc; on pm_ack&enable latch instr/oprnd, pc<=pc+1.
//    If 2-word opcode, go FETCH2; else EXEC. No ack: hold, pm_addr stable.
//  - FETCH2: same handshake; ea <= {oprnd,word}[AW-1:0]; pc<=pc+1; -> EXEC.
//  - EXEC: one cycle, -> FETCH. LD/ADDM instead assert dm_re, go MEMWAIT; next cycle consume dm_rdata, -> FETCH.
//  pc wraps 2^AW-1 -> 0. Single-word insn = 2 cycles min; 2-word = 3 min (4 for LD/ADDM).
//  Opcodes (imm=oprnd):
//    0 NOP; 1 LIT A<=imm; 2 IN A<=in_port; 3 OUT.
//    4 ADDI; 5 SUBI; 6 NANDI; 7 CMPI (SUBI flags only, A kept).
//    8 LD A<=M[ea]; 9 ST M[ea]<=A; A ADDM A<=A+M[ea].
//    B JMP; C JC; D JZ (taken: pc<=ea); E CALL push pc, pc<=ea.
//    F: imm==0 RET pops pc; imm!=0 HALT.
//  Arithmetic: (DW+1)-bit result. ADD: C=bit DW. SUB: C=borrow (A<imm). Z=(result[DW-1:0]==0).
//  NANDI: C<=0, Z updated. LIT/IN/LD leave flags unchanged.
//  Stack: CALL when full, or RET when empty -> no push/pop, pc unchanged from ea fetch, fault=1, -> HALT.
//  HALT: no requests; left only by reset.
//  enable=0 honoured only in FETCH; mid-instruction states complete regardless.
// STRUCTURE
//  up_pkg: opcode localparams, FSM state encoding, is_two_word() function.
//  Sub-module up_call_stack (DEPTH, AW): push/pop/full/empty, sync active-low reset. Rest inline.
// TESTING (DW=4, AW=12, STACK_DEPTH=4, zero-wait memory unless noted)
//  1 reset low 2 cycles mid-FETCH2 -> pc=0, accu=0, flags 0, pm_req=0; first cycle after: pm_req=1, pm_addr=0.
//  2 LIT F, ADDI 1 -> accu=0, c=1, z=1; LIT 3, SUBI 5 -> accu=E, c=1, z=0; CMPI 3 after LIT 3 -> z=1, accu=3.
//  3 pm_ack delayed 3 cycles per word -> pm_addr/pc held, instr latched only on ack; enable=0 in FETCH -> pm_req=0, pc frozen.
//  4 CMPI equal then JZ 0x123 -> pc=0x123; JC with c=0 -> not taken, pc=old+2.
//  5 4 nested CALLs then 4 RETs -> pc returns to each call+2; 5th nested CALL -> fault=1, halted=1, pm_req=0 forever.
//  6 LIT 7, ST 0xA55, LIT 0, LD 0xA55 -> dm_we 1 cycle @0xA55 data 7; dm_re then accu=7; OUT -> out_port=7, out_valid 1 cycle.

Source files
------------

// File: rtl/up_pkg.sv
// Shared definitions for the up_seq_core accumulator CPU: opcode map,
// fetch/execute state encoding and instruction-length decode.
package up_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LIT   = 4'h1;
    localparam logic [3:0] OP_IN    = 4'h2;
    localparam logic [3:0] OP_OUT   = 4'h3;
    localparam logic [3:0] OP_ADDI  = 4'h4;
    localparam logic [3:0] OP_SUBI  = 4'h5;
    localparam logic [3:0] OP_NANDI = 4'h6;
    localparam logic [3:0] OP_CMPI  = 4'h7;
    localparam logic [3:0] OP_LD    = 4'h8;
    localparam logic [3:0] OP_ST    = 4'h9;
    localparam logic [3:0] OP_ADDM  = 4'hA;
    localparam logic [3:0] OP_JMP   = 4'hB;
    localparam logic [3:0] OP_JC    = 4'hC;
    localparam logic [3:0] OP_JZ    = 4'hD;
    localparam logic [3:0] OP_CALL  = 4'hE;
    localparam logic [3:0] OP_SYS   = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_FETCH2  = 3'd1,
        S_EXEC    = 3'd2,
        S_MEMWAIT = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    // Memory-addressed and control-transfer opcodes carry a second address word.
    function automatic logic is_two_word(input logic [3:0] op);
        return (op >= OP_LD) && (op <= OP_CALL);
    endfunction

endpackage

// File: rtl/up_call_stack.sv
// Return-address LIFO for CALL/RET. Push and pop are ignored when full/empty;
// the core decides what an overflow or underflow means.
module up_call_stack #(
    parameter int DEPTH = 4,
    parameter int AW    = 12
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [AW-1:0] i_data,
    output logic [AW-1:0] o_top,
    output logic          o_full,
    output logic          o_empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] r_mem [0:DEPTH-1];
    logic [CW-1:0] r_count;
    logic [IW-1:0] w_top_idx;
    logic [IW-1:0] w_wr_idx;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_top_idx = IW'(r_count - CW'(1));
    assign w_wr_idx  = IW'(r_count);

    always_comb begin
        o_top = '0;
        if (!o_empty)
            o_top = r_mem[w_top_idx];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (i_push && !o_full) begin
            r_mem[w_wr_idx] <= i_data;
            r_count         <= r_count + CW'(1);
        end else if (i_pop && !o_empty) begin
            r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/up_seq_core.sv
// Accumulator CPU core: handshaked instruction fetch (1 or 2 words), single-cycle
// execute, one-cycle data-RAM read wait, hardware call stack and HALT/fault stop.
module up_seq_core
    import up_pkg::*;
#(
    parameter int DW          = 4,
    parameter int AW          = 12,
    parameter int STACK_DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    output logic          pm_req,
    output logic [AW-1:0] pm_addr,
    input  logic          pm_ack,
    input  logic [DW+3:0] pm_rdata,
    output logic [AW-1:0] dm_addr,
    output logic          dm_we,
    output logic          dm_re,
    output logic [DW-1:0] dm_wdata,
    input  logic [DW-1:0] dm_rdata,
    input  logic [DW-1:0] in_port,
    output logic [DW-1:0] out_port,
    output logic          out_valid,
    output logic [AW-1:0] pc,
    output logic [3:0]    instr,
    output logic [DW-1:0] oprnd,
    output logic [DW-1:0] accu,
    output logic          c_flag,
    output logic          z_flag,
    output logic          phase,
    output logic          halted,
    output logic          fault
);

    state_t          r_state;
    logic [AW-1:0]   r_pc;
    logic [AW-1:0]   r_ea;
    logic [3:0]      r_instr;
    logic [DW-1:0]   r_oprnd;
    logic [DW-1:0]   r_accu;
    logic            r_c;
    logic            r_z;
    logic [DW-1:0]   r_out;
    logic            r_out_valid;
    logic            r_fault;

    logic [DW:0]     w_add_imm;
    logic [DW:0]     w_sub_imm;
    logic [DW:0]     w_add_mem;
    logic [DW-1:0]   w_nand;
    logic [2*DW+3:0] w_ea_full;
    logic            w_is_ret;
    logic            w_push;
    logic            w_pop;
    logic [AW-1:0]   w_ret_addr;
    logic            w_stk_full;
    logic            w_stk_empty;

    // Bit DW of each extended result is the carry (ADD) or borrow (SUB).
    assign w_add_imm = {1'b0, r_accu} + {1'b0, r_oprnd};
    assign w_sub_imm = {1'b0, r_accu} - {1'b0, r_oprnd};
    assign w_add_mem = {1'b0, r_accu} + {1'b0, dm_rdata};
    assign w_nand    = ~(r_accu & r_oprnd);
    assign w_ea_full = {r_oprnd, pm_rdata};
    assign w_is_ret  = (r_instr == OP_SYS) && (r_oprnd == '0);

    assign w_push = (r_state == S_EXEC) && (r_instr == OP_CALL) && !w_stk_full;
    assign w_pop  = (r_state == S_EXEC) && w_is_ret && !w_stk_empty;

    up_call_stack #(
        .DEPTH (STACK_DEPTH),
        .AW    (AW)
    ) u_stack (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (r_pc),
        .o_top   (w_ret_addr),
        .o_full  (w_stk_full),
        .o_empty (w_stk_empty)
    );

    // Strobes are forced low while reset is held so no request escapes that cycle.
    assign pm_req = reset && (((r_state == S_FETCH) && enable) || (r_state == S_FETCH2));
    assign dm_re  = reset && (r_state == S_EXEC) && ((r_instr == OP_LD) || (r_instr == OP_ADDM));
    assign dm_we  = reset && (r_state == S_EXEC) && (r_instr == OP_ST);

    assign pm_addr   = r_pc;
    assign pc        = r_pc;
    assign dm_addr   = r_ea;
    assign dm_wdata  = r_accu;
    assign out_port  = r_out;
    assign out_valid = r_out_valid;
    assign instr     = r_instr;
    assign oprnd     = r_oprnd;
    assign accu      = r_accu;
    assign c_flag    = r_c;
    assign z_flag    = r_z;
    assign phase     = (r_state == S_EXEC) || (r_state == S_MEMWAIT);
    assign halted    = (r_state == S_HALT);
    assign fault     = r_fault;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= S_FETCH;
            r_pc        <= '0;
            r_ea        <= '0;
            r_instr     <= '0;
            r_oprnd     <= '0;
            r_accu      <= '0;
            r_c         <= 1'b0;
            r_z         <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (enable && pm_ack) begin
                        r_instr <= pm_rdata[DW+3:DW];
                        r_oprnd <= pm_rdata[DW-1:0];
                        r_pc    <= r_pc + AW'(1);
                        r_state <= is_two_word(pm_rdata[DW+3:DW]) ? S_FETCH2 : S_EXEC;
                    end
                end
                S_FETCH2: begin
                    if (pm_ack) begin
                        r_ea    <= w_ea_full[AW-1:0];
                        r_pc    <= r_pc + AW'(1);
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_state <= S_FETCH;
                    case (r_instr)
                        OP_LIT: r_accu <= r_oprnd;
                        OP_IN:  r_accu <= in_port;
                        OP_OUT: begin
                            r_out       <= r_accu;
                            r_out_valid <= 1'b1;
                        end
                        OP_ADDI: begin
                            r_accu <= w_add_imm[DW-1:0];
                            r_c    <= w_add_imm[DW];
                            r_z    <= (w_add_imm[DW-1:0] == '0);
                        end
                        OP_SUBI: begin
                            r_accu <= w_sub_imm[DW-1:0];
                            r_c    <= w_sub_imm[DW];
                            r_z    <= (w_sub_imm[DW-1:0] == '0);
                        end
                        OP_NANDI: begin
                            r_accu <= w_nand;
                            r_c    <= 1'b0;
                            r_z    <= (w_nand == '0);
                        end
                        OP_CMPI: begin
                            r_c <= w_sub_imm[DW];
                            r_z <= (w_sub_imm[DW-1:0] == '0);
                        end
                        OP_LD, OP_ADDM: r_state <= S_MEMWAIT;
                        OP_JMP: r_pc <= r_ea;
                        OP_JC:  if (r_c) r_pc <= r_ea;
                        OP_JZ:  if (r_z) r_pc <= r_ea;
                        OP_CALL: begin
                            if (w_stk_full) begin
                                r_fault <= 1'b1;
                                r_state <= S_HALT;
                            end else begin
                                r_pc <= r_ea;
                            end
                        end
                        OP_SYS: begin
                            if (!w_is_ret) begin
                                r_state <= S_HALT;
                            end else if (w_stk_empty) begin
                                r_fault <= 1'b1;
                                r_state <= S_HALT;
                            end else begin
                                r_pc <= w_ret_addr;
                            end
                        end
                        default: ;
                    endcase
                end
                S_MEMWAIT: begin
                    r_state <= S_FETCH;
                    if (r_instr == OP_ADDM) begin
                        r_accu <= w_add_mem[DW-1:0];
                        r_c    <= w_add_mem[DW];
                        r_z    <= (w_add_mem[DW-1:0] == '0);
                    end else begin
                        r_accu <= dm_rdata;
                    end
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_up_seq_core.sv
// Directed bench for up_seq_core: program ROM with adjustable ack latency and
// a one-cycle-read data RAM model surround the core.
module tb_up_seq_core;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        pm_req;
    logic [11:0] pm_addr;
    logic        pm_ack;
    logic [7:0]  pm_rdata;
    logic [11:0] dm_addr;
    logic        dm_we;
    logic        dm_re;
    logic [3:0]  dm_wdata;
    logic [3:0]  dm_rdata;
    logic [3:0]  in_port;
    logic [3:0]  out_port;
    logic        out_valid;
    logic [11:0] pc;
    logic [3:0]  instr;
    logic [3:0]  oprnd;
    logic [3:0]  accu;
    logic        c_flag;
    logic        z_flag;
    logic        phase;
    logic        halted;
    logic        fault;

    logic [7:0]  prog [0:4095];
    logic [3:0]  dmem [0:4095];
    int          ack_delay;
    int          wcnt;
    int          we_cnt;
    int          re_cnt;
    logic [11:0] we_addr;
    logic [3:0]  we_data;
    logic [11:0] re_addr;
    int          checks;
    int          errors;

    up_seq_core #(.DW(4), .AW(12), .STACK_DEPTH(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .pm_req   (pm_req),
        .pm_addr  (pm_addr),
        .pm_ack   (pm_ack),
        .pm_rdata (pm_rdata),
        .dm_addr  (dm_addr),
        .dm_we    (dm_we),
        .dm_re    (dm_re),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .in_port  (in_port),
        .out_port (out_port),
        .out_valid(out_valid),
        .pc       (pc),
        .instr    (instr),
        .oprnd    (oprnd),
        .accu     (accu),
        .c_flag   (c_flag),
        .z_flag   (z_flag),
        .phase    (phase),
        .halted   (halted),
        .fault    (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Program ROM: acks after ack_delay waiting cycles of a held request.
    assign pm_rdata = prog[pm_addr];
    assign pm_ack   = pm_req && (wcnt >= ack_delay);

    always @(posedge clock) begin
        if (!pm_req || pm_ack) wcnt <= 0;
        else                   wcnt <= wcnt + 1;
    end

    always @(posedge clock) begin
        if (dm_we) dmem[dm_addr] <= dm_wdata;
        if (dm_re) dm_rdata <= dmem[dm_addr];
    end

    initial begin
        we_cnt = 0;
        re_cnt = 0;
        we_addr = '0;
        we_data = '0;
        re_addr = '0;
        wcnt = 0;
        dm_rdata = '0;
    end

    always @(negedge clock) begin
        if (dm_we) begin
            we_cnt  = we_cnt + 1;
            we_addr = dm_addr;
            we_data = dm_wdata;
        end
        if (dm_re) begin
            re_cnt  = re_cnt + 1;
            re_addr = dm_addr;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 4096; i++) prog[i] = 8'h00;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        enable = 1'b1;
        tick(2);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_prog();
        prog[0] = 8'h15;
        prog[1] = 8'hB0;
        prog[2] = 8'h00;
        ack_delay = 0;
        do_reset();
        checks++; if (pc !== 12'h000 || accu !== 4'h0 || fault !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL rst_init pc=%h accu=%h fault=%b halted=%b required 000/0/0/0", pc, accu, fault, halted); end
        tick(3);
        ack_delay = 5;
        checks++; if (instr !== 4'hB || pc !== 12'h002 || accu !== 4'h5) begin errors++; $display("FAIL rst_pre instr=%h pc=%h accu=%h required B/002/5", instr, pc, accu); end
        tick(1);
        reset = 1'b0;
        #1;
        checks++; if (pm_req !== 1'b0) begin errors++; $display("FAIL rst_req_now got %b required 0", pm_req); end
        tick(2);
        checks++; if (pc !== 12'h000 || accu !== 4'h0 || c_flag !== 1'b0 || z_flag !== 1'b0) begin errors++; $display("FAIL rst_regs pc=%h accu=%h c=%b z=%b required 000/0/0/0", pc, accu, c_flag, z_flag); end
        checks++; if (pm_req !== 1'b0 || instr !== 4'h0 || phase !== 1'b0) begin errors++; $display("FAIL rst_ctl pm_req=%b instr=%h phase=%b required 0/0/0", pm_req, instr, phase); end
        reset = 1'b1;
        ack_delay = 0;
        #1;
        checks++; if (pm_req !== 1'b1 || pm_addr !== 12'h000) begin errors++; $display("FAIL rst_first pm_req=%b pm_addr=%h required 1/000", pm_req, pm_addr); end
    endtask

    task automatic test_arith();
        clear_prog();
        prog[0] = 8'h1F; prog[1] = 8'h41;
        prog[2] = 8'h13; prog[3] = 8'h55;
        prog[4] = 8'h13; prog[5] = 8'h73;
        prog[6] = 8'h6C; prog[7] = 8'hF1;
        ack_delay = 0;
        do_reset();
        tick(4);
        checks++; if (accu !== 4'h0 || c_flag !== 1'b1 || z_flag !== 1'b1) begin errors++; $display("FAIL addi_wrap accu=%h c=%b z=%b required 0/1/1", accu, c_flag, z_flag); end
        tick(4);
        checks++; if (accu !== 4'hE || c_flag !== 1'b1 || z_flag !== 1'b0) begin errors++; $display("FAIL subi_borrow accu=%h c=%b z=%b required E/1/0", accu, c_flag, z_flag); end
        tick(4);
        checks++; if (accu !== 4'h3 || c_flag !== 1'b0 || z_flag !== 1'b1) begin errors++; $display("FAIL cmpi_eq accu=%h c=%b z=%b required 3/0/1", accu, c_flag, z_flag); end
        tick(2);
        checks++; if (accu !== 4'hF || c_flag !== 1'b0 || z_flag !== 1'b0) begin errors++; $display("FAIL nandi accu=%h c=%b z=%b required F/0/0", accu, c_flag, z_flag); end
        tick(2);
        checks++; if (halted !== 1'b1 || pm_req !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL halt halted=%b pm_req=%b fault=%b required 1/0/0", halted, pm_req, fault); end
    endtask

    task automatic test_handshake();
        clear_prog();
        prog[0] = 8'h15;
        prog[1] = 8'hF1;
        ack_delay = 3;
        do_reset();
        tick(3);
        checks++; if (pm_req !== 1'b1 || pm_addr !== 12'h000 || pc !== 12'h000 || instr !== 4'h0) begin errors++; $display("FAIL hs_wait req=%b addr=%h pc=%h instr=%h required 1/000/000/0", pm_req, pm_addr, pc, instr); end
        tick(1);
        checks++; if (instr !== 4'h1 || oprnd !== 4'h5 || pc !== 12'h001 || phase !== 1'b1) begin errors++; $display("FAIL hs_latch instr=%h oprnd=%h pc=%h phase=%b required 1/5/001/1", instr, oprnd, pc, phase); end
        tick(1);
        checks++; if (accu !== 4'h5 || phase !== 1'b0) begin errors++; $display("FAIL hs_exec accu=%h phase=%b required 5/0", accu, phase); end
        enable = 1'b0;
        #1;
        checks++; if (pm_req !== 1'b0) begin errors++; $display("FAIL en_req got %b required 0", pm_req); end
        tick(5);
        checks++; if (pc !== 12'h001 || pm_req !== 1'b0 || phase !== 1'b0 || instr !== 4'h1) begin errors++; $display("FAIL en_frozen pc=%h req=%b phase=%b instr=%h required 001/0/0/1", pc, pm_req, phase, instr); end
        enable = 1'b1;
        tick(3);
        checks++; if (pc !== 12'h001 || pm_addr !== 12'h001) begin errors++; $display("FAIL hs_hold2 pc=%h addr=%h required 001/001", pc, pm_addr); end
        tick(1);
        checks++; if (pc !== 12'h002 || instr !== 4'hF || phase !== 1'b1) begin errors++; $display("FAIL hs_ack2 pc=%h instr=%h phase=%b required 002/F/1", pc, instr, phase); end
        tick(1);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL hs_halt got %b required 1", halted); end
    endtask

    task automatic test_jump();
        clear_prog();
        prog[0] = 8'h13; prog[1] = 8'h73;
        prog[2] = 8'hD1; prog[3] = 8'h23;
        prog[12'h123] = 8'hC4; prog[12'h124] = 8'h56;
        prog[12'h125] = 8'hF1;
        ack_delay = 0;
        do_reset();
        tick(7);
        checks++; if (pc !== 12'h123) begin errors++; $display("FAIL jz_taken pc=%h required 123", pc); end
        tick(3);
        checks++; if (pc !== 12'h125) begin errors++; $display("FAIL jc_not_taken pc=%h required 125", pc); end
        tick(2);
        checks++; if (halted !== 1'b1 || fault !== 1'b0 || pc !== 12'h126) begin errors++; $display("FAIL jmp_halt halted=%b fault=%b pc=%h required 1/0/126", halted, fault, pc); end
    endtask

    task automatic test_stack();
        int bad;
        clear_prog();
        prog[12'h000] = 8'hE0; prog[12'h001] = 8'h10;
        prog[12'h010] = 8'hE0; prog[12'h011] = 8'h20;
        prog[12'h020] = 8'hE0; prog[12'h021] = 8'h30;
        prog[12'h030] = 8'hE0; prog[12'h031] = 8'h40;
        prog[12'h040] = 8'hF0;
        prog[12'h032] = 8'hF0;
        prog[12'h022] = 8'hF0;
        prog[12'h012] = 8'hF0;
        prog[12'h002] = 8'hE0; prog[12'h003] = 8'h50;
        prog[12'h050] = 8'hE0; prog[12'h051] = 8'h60;
        prog[12'h060] = 8'hE0; prog[12'h061] = 8'h70;
        prog[12'h070] = 8'hE0; prog[12'h071] = 8'h80;
        prog[12'h080] = 8'hE0; prog[12'h081] = 8'h90;
        ack_delay = 0;
        do_reset();
        tick(3);
        checks++; if (pc !== 12'h010) begin errors++; $display("FAIL call1 pc=%h required 010", pc); end
        tick(9);
        checks++; if (pc !== 12'h040) begin errors++; $display("FAIL call4 pc=%h required 040", pc); end
        tick(2);
        checks++; if (pc !== 12'h032) begin errors++; $display("FAIL ret1 pc=%h required 032", pc); end
        tick(6);
        checks++; if (pc !== 12'h002 || fault !== 1'b0) begin errors++; $display("FAIL ret4 pc=%h fault=%b required 002/0", pc, fault); end
        tick(12);
        checks++; if (pc !== 12'h080 || fault !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL call_full pc=%h fault=%b halted=%b required 080/0/0", pc, fault, halted); end
        tick(3);
        checks++; if (fault !== 1'b1 || halted !== 1'b1 || pc !== 12'h082) begin errors++; $display("FAIL overflow fault=%b halted=%b pc=%h required 1/1/082", fault, halted, pc); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (pm_req !== 1'b0 || halted !== 1'b1) bad++;
            tick(1);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL halt_stuck bad_cycles=%0d required 0", bad); end
    endtask

    task automatic test_underflow();
        clear_prog();
        prog[0] = 8'hF0;
        ack_delay = 0;
        do_reset();
        tick(2);
        checks++; if (fault !== 1'b1 || halted !== 1'b1 || pc !== 12'h001) begin errors++; $display("FAIL underflow fault=%b halted=%b pc=%h required 1/1/001", fault, halted, pc); end
    endtask

    task automatic test_memory();
        int we0;
        int re0;
        clear_prog();
        prog[0] = 8'h17;
        prog[1] = 8'h9A; prog[2] = 8'h55;
        prog[3] = 8'h10;
        prog[4] = 8'h8A; prog[5] = 8'h55;
        prog[6] = 8'h30;
        prog[7] = 8'hF1;
        ack_delay = 0;
        do_reset();
        we0 = we_cnt;
        re0 = re_cnt;
        tick(5);
        checks++; if (we_cnt - we0 != 1 || we_addr !== 12'hA55 || we_data !== 4'h7) begin errors++; $display("FAIL st_strobe count=%0d addr=%h data=%h required 1/A55/7", we_cnt - we0, we_addr, we_data); end
        tick(2);
        checks++; if (accu !== 4'h0 || dmem[12'hA55] !== 4'h7) begin errors++; $display("FAIL lit0 accu=%h mem=%h required 0/7", accu, dmem[12'hA55]); end
        tick(4);
        checks++; if (accu !== 4'h7 || re_cnt - re0 != 1 || re_addr !== 12'hA55) begin errors++; $display("FAIL ld accu=%h re_count=%0d addr=%h required 7/1/A55", accu, re_cnt - re0, re_addr); end
        tick(2);
        checks++; if (out_port !== 4'h7 || out_valid !== 1'b1) begin errors++; $display("FAIL out port=%h valid=%b required 7/1", out_port, out_valid); end
        tick(1);
        checks++; if (out_valid !== 1'b0 || out_port !== 4'h7 || we_cnt - we0 != 1) begin errors++; $display("FAIL out_pulse valid=%b port=%h we_count=%0d required 0/7/1", out_valid, out_port, we_cnt - we0); end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        enable  = 1'b1;
        in_port = 4'h0;
        ack_delay = 0;
        test_reset();
        test_arith();
        test_handshake();
        test_jump();
        test_stack();
        test_underflow();
        test_memory();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
